ebr_wr_packer: RTL and testbench

//  Write-side front end for the 18-bit-write / 9-bit-read pseudo-dual-port EBR.

---
 rtl/ebr_pkg.sv | 9 +
 rtl/ebr_idle_timer.sv | 24 ++
 rtl/ebr_wr_packer.sv | 90 +++++++++
 tb/tb_ebr_wr_packer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ebr_pkg.sv
// ebr_pkg: shared widths, byte-enable codes and packer state for the EBR write path
package ebr_pkg;
  localparam int EBR_BYTE_W = 9;
  localparam int EBR_WORD_W = 18;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_BOTH = 2'b11;
  typedef enum logic {EMPTY, HELD} pk_state_t;
endpackage

// File: rtl/ebr_idle_timer.sv
// ebr_idle_timer: counts enabled idle cycles, pulses tc at TIMEOUT; TIMEOUT=0 disables
module ebr_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  generate
    if (TIMEOUT == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !tc) cnt <= cnt + CW'(1);
      assign tc = en && (cnt == CW'(TIMEOUT));
    end
  endgenerate
endmodule

// File: rtl/ebr_wr_packer.sv
// ebr_wr_packer: packs a 9-bit byte stream into 18-bit EBR writes over a circular buffer
module ebr_wr_packer
  import ebr_pkg::*;
#(
  parameter int ADDR_W        = 9,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EBR_BYTE_W-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  input  logic [ADDR_W+1:0]     rd_ptr,
  output logic [EBR_WORD_W-1:0] di,
  output logic [ADDR_W-1:0]     adw,
  output logic [1:0]            be,
  output logic                  cew,
  output logic [ADDR_W+1:0]     wr_ptr,
  output logic [ADDR_W+1:0]     level,
  output logic                  full
);
  localparam int PW = ADDR_W + 2;
  pk_state_t state, state_n;
  logic [EBR_BYTE_W-1:0] hold, hold_n;
  logic [EBR_WORD_W-1:0] di_n;
  logic [ADDR_W-1:0] adw_n;
  logic [1:0] be_n;
  logic cew_n, acc, tc, fl;
  logic [PW-1:0] wr_ptr_n;
  assign acc     = s_valid && s_ready;
  assign fl      = flush || tc;
  assign level   = wr_ptr + PW'(state == HELD) - rd_ptr;
  assign full    = level == (PW'(1) << (ADDR_W + 1));
  assign s_ready = !full;
  ebr_idle_timer #(.TIMEOUT(FLUSH_TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (acc || state == EMPTY),
    .en  (state == HELD),
    .tc  (tc)
  );
  // A held byte always sits in lane 0, so any write address is simply wr_ptr's word.
  always_comb begin
    state_n  = state;
    hold_n   = hold;
    wr_ptr_n = wr_ptr;
    di_n     = di;
    adw_n    = adw;
    be_n     = be;
    cew_n    = 1'b0;
    if (state == EMPTY) begin
      if (acc && !wr_ptr[0]) begin
        hold_n  = s_data;
        state_n = HELD;
      end else if (acc) begin
        cew_n    = 1'b1;
        be_n     = BE_HI;
        di_n     = {s_data, {EBR_BYTE_W{1'b0}}};
        adw_n    = wr_ptr[ADDR_W:1];
        wr_ptr_n = wr_ptr + PW'(1);
      end
    end else if (acc || fl) begin
      cew_n    = 1'b1;
      be_n     = acc ? BE_BOTH : BE_LO;
      di_n     = {acc ? s_data : {EBR_BYTE_W{1'b0}}, hold};
      adw_n    = wr_ptr[ADDR_W:1];
      wr_ptr_n = wr_ptr + (acc ? PW'(2) : PW'(1));
      state_n  = EMPTY;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= EMPTY;
      hold   <= '0;
      wr_ptr <= '0;
      di     <= '0;
      adw    <= '0;
      be     <= '0;
      cew    <= 1'b0;
    end else begin
      state  <= state_n;
      hold   <= hold_n;
      wr_ptr <= wr_ptr_n;
      di     <= di_n;
      adw    <= adw_n;
      be     <= be_n;
      cew    <= cew_n;
    end
endmodule

// File: tb/tb_ebr_wr_packer.sv
// tb_ebr_wr_packer: byte-stream model predicts every EBR write, pointer, level and ready
module tb_ebr_wr_packer;
  localparam int ADDR_W = 9;
  localparam int TO     = 16;
  localparam int CAP    = 1 << (ADDR_W + 1);
  localparam int PMASK  = (1 << (ADDR_W + 2)) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [8:0] s_data = '0;
  logic s_valid = 1'b0, flush = 1'b0, s_ready;
  logic [ADDR_W+1:0] rd_ptr = '0, wr_ptr, level;
  logic [17:0] di;
  logic [ADDR_W-1:0] adw;
  logic [1:0] be;
  logic cew, full;
  logic s_valid0 = 1'b0, s_ready0, cew0, full0;
  logic [17:0] di0;
  logic [ADDR_W-1:0] adw0;
  logic [1:0] be0;
  logic [ADDR_W+1:0] wr_ptr0, level0;
  int errors = 0, checks = 0;
  int n_acc, n_com, idle, rd;
  logic [8:0] mem [0:CAP*4-1];

  ebr_wr_packer #(.ADDR_W(ADDR_W), .FLUSH_TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .rd_ptr(rd_ptr), .di(di), .adw(adw), .be(be), .cew(cew),
    .wr_ptr(wr_ptr), .level(level), .full(full));

  ebr_wr_packer #(.ADDR_W(ADDR_W), .FLUSH_TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid0), .s_ready(s_ready0),
    .flush(1'b0), .rd_ptr('0), .di(di0), .adw(adw0), .be(be0), .cew(cew0),
    .wr_ptr(wr_ptr0), .level(level0), .full(full0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lvl_m();
    return (n_acc - rd) & PMASK;
  endfunction

  task automatic do_reset();
    rd = 0;
    rd_ptr = '0;
    rst = 1'b1;
    #1;
    check("rst_cew", cew, 0);
    check("rst_di", di, 0);
    check("rst_adw", adw, 0);
    check("rst_be", be, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_acc = 0;
    n_com = 0;
    idle = 0;
    check("rst_ready", s_ready, 1);
  endtask

  // One clock: predict from the byte-stream model, advance it, compare after the edge.
  task automatic step(input logic v, input logic [8:0] d, input logic f);
    bit a, ecew;
    int ebe, edi, eadw, inc, held;
    s_valid = v;
    s_data = d;
    flush = f;
    rd_ptr = (ADDR_W + 2)'(rd);
    #1;
    check("level", level, lvl_m());
    check("full", full, int'(lvl_m() == CAP));
    check("s_ready", s_ready, int'(lvl_m() != CAP));
    a = v && (lvl_m() != CAP);
    held = n_acc - n_com;
    ecew = 0; ebe = 0; edi = 0; eadw = 0; inc = 0;
    if (a && (n_acc & 1) == 1) begin
      ecew = 1;
      eadw = (n_acc >> 1) % (1 << ADDR_W);
      inc = held + 1;
      ebe = held ? 3 : 2;
      edi = (int'(d) << 9) | (held ? int'(mem[(n_acc - 1) % (CAP*4)]) : 0);
    end else if (!a && held == 1 && (f || idle == TO)) begin
      ecew = 1;
      eadw = (n_com >> 1) % (1 << ADDR_W);
      inc = 1;
      ebe = 1;
      edi = int'(mem[n_com % (CAP*4)]);
    end
    if (a) begin
      mem[n_acc % (CAP*4)] = d;
      n_acc++;
    end
    n_com += inc;
    idle = (a || n_acc == n_com) ? 0 : idle + 1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    flush = 1'b0;
    check("cew", cew, int'(ecew));
    if (ecew) begin
      check("be", be, ebe);
      check("di", di, edi);
      check("adw", adw, eadw);
    end
    check("wr_ptr", wr_ptr, n_com & PMASK);
  endtask

  initial begin
    int lat, n0;
    do_reset();
    // stream pair from reset
    step(1, 9'h101, 0);
    step(1, 9'h0A2, 0);
    check("t1_di", di, 18'h14501);
    check("t1_be", be, 3);
    check("t1_wr_ptr", wr_ptr, 2);
    // partial flush then lane-1 completion
    do_reset();
    step(1, 9'h1FF, 0);
    step(0, 9'h000, 1);
    check("t2_flush_be", be, 1);
    check("t2_flush_lo", int'(di[8:0]), 9'h1FF);
    check("t2_flush_ptr", wr_ptr, 1);
    step(1, 9'h055, 0);
    check("t2_hi_be", be, 2);
    check("t2_hi_adw", adw, 0);
    check("t2_hi_ptr", wr_ptr, 2);
    // idle auto-flush latency, and no auto-flush when disabled
    do_reset();
    s_valid0 = 1'b1;
    step(1, 9'h0AA, 0);
    s_valid0 = 1'b0;
    lat = -1;
    n0 = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 9'h000, 0);
      if (cew && lat < 0) lat = k;
      if (cew0) n0++;
    end
    check("t3_timeout_lat", lat, 17);
    check("t3_no_to_cew", n0, 0);
    check("t3_no_to_level", level0, 1);
    // fill to capacity, then free one word
    do_reset();
    for (int k = 0; k < CAP; k++) step(1, 9'($urandom), 0);
    check("t4_full", full, 1);
    check("t4_ready", s_ready, 0);
    check("t4_level", level, CAP);
    step(1, 9'h123, 0);
    rd = 2;
    step(1, 9'h0C3, 0);
    step(1, 9'h13C, 0);
    check("t4_wrap_adw", adw, 0);
    check("t4_wrap_cew", cew, 1);
    // flush coincident with completion, flush in empty
    do_reset();
    step(1, 9'h011, 0);
    step(1, 9'h022, 1);
    check("t5_coinc_be", be, 3);
    step(0, 9'h000, 0);
    check("t5_no_extra", cew, 0);
    step(0, 9'h000, 1);
    check("t5_empty_flush", cew, 0);
    // reset mid-write and while holding
    step(1, 9'h033, 0);
    step(1, 9'h044, 0);
    check("t6_mid_cew", cew, 1);
    do_reset();
    step(1, 9'h077, 0);
    do_reset();
    step(1, 9'h188, 0);
    step(1, 9'h099, 0);
    check("t6_restart_adw", adw, 0);
    check("t6_restart_di", di, 18'h13388);
    // randomized traffic with consumer, flushes and idle gaps
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 3 == 0 && n_com > rd) rd += $urandom_range(0, n_com - rd);
      assert (rd <= n_com);
      step((i % 200 >= 25) && ($urandom % 4 != 0), 9'($urandom), $urandom % 16 == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
